// File: rtl/feed_bundle_arbiter_if.sv
// feed_bundle_arbiter_if: per-source beat handshakes plus the merged stream and bundle counters.
// The arbiter connects through the slave modport; the feed sources and the fifo connect through master.
interface feed_bundle_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int MSG_W = 245
);
    logic [N_REQ-1:0]         req_v;
    logic [N_REQ-1:0]         req_r;
    logic [N_REQ*MSG_W-1:0]   req_d;
    logic [N_REQ-1:0]         req_last;
    logic                     out_v;
    logic                     out_r;
    logic [MSG_W-1:0]         out_d;
    logic                     out_last;
    logic [$clog2(N_REQ)-1:0] out_src;
    logic [N_REQ*32-1:0]      bundle_cnt;
    logic                     timeout_err;
    modport slave (
        input  req_v, req_d, req_last, out_r,
        output req_r, out_v, out_d, out_last, out_src, bundle_cnt, timeout_err
    );
    modport master (
        output req_v, req_d, req_last, out_r,
        input  req_r, out_v, out_d, out_last, out_src, bundle_cnt, timeout_err
    );
endinterface

// File: rtl/feed_bundle_arbiter.sv
// feed_bundle_arbiter: round-robin arbiter granting whole bundles onto one ingress stream.
// Optional idle-beat timeout release is enabled by defining PIPEBOMB_BUNDLE_TIMEOUT_EN.
module feed_bundle_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MSG_W   = 245,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    feed_bundle_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TW < 1) begin : g_bad_cfg
        $error("feed_bundle_arbiter: unsupported N_REQ/TIMEOUT");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q;
    logic [SW-1:0]         grant_q, grant_d;
    logic [SW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [N_REQ*32-1:0]   cnt_q;
    logic [N_REQ-1:0]      rot, gnt_oh;
    logic [SW-1:0]         off;
    logic [SW:0]           sum;
    logic                  busy, sel_v, sel_last, fire;
    logic [MSG_W-1:0]      sel_d;

    // Rotate requests so bit 0 is the rr_ptr source; the lowest set bit wins.
    always_comb begin
        rot = (bus.req_v >> rr_ptr_q) | (bus.req_v << (N_REQ - int'(rr_ptr_q)));
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = SW'(k);
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        grant_d = (sum >= (SW+1)'(N_REQ)) ? SW'(sum - (SW+1)'(N_REQ)) : sum[SW-1:0];
        rr_ptr_d = (grant_q == SW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    always_comb begin
        sel_v = 1'b0;
        sel_last = 1'b0;
        sel_d = '0;
        gnt_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == SW'(i)) begin
                sel_v = bus.req_v[i];
                sel_last = bus.req_last[i];
                sel_d = bus.req_d[i*MSG_W +: MSG_W];
                gnt_oh[i] = 1'b1;
            end
        end
    end

    assign busy           = (state_q == BUSY);
    assign fire           = busy & sel_v & bus.out_r;
    assign bus.out_v      = busy & sel_v;
    assign bus.out_d      = sel_d;
    assign bus.out_last   = sel_last;
    assign bus.out_src    = grant_q;
    assign bus.req_r      = (busy & bus.out_r) ? gnt_oh : '0;
    assign bus.bundle_cnt = cnt_q;

`ifdef PIPEBOMB_BUNDLE_TIMEOUT_EN
    logic [TW-1:0] idle_q;
    logic          timeout_q;
    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef PIPEBOMB_BUNDLE_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef PIPEBOMB_BUNDLE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (state_q == IDLE) begin
                if (|bus.req_v) begin
                    grant_q <= grant_d;
                    state_q <= BUSY;
                end
            end else begin
                if (fire && sel_last) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= rr_ptr_d;
                    for (int i = 0; i < N_REQ; i++)
                        if (gnt_oh[i]) cnt_q[i*32 +: 32] <= cnt_q[i*32 +: 32] + 32'd1;
                end
`ifdef PIPEBOMB_BUNDLE_TIMEOUT_EN
                // Forced release abandons the bundle without counting it.
                if (sel_v) idle_q <= '0;
                else if (idle_q == TW'(TIMEOUT - 1)) begin
                    idle_q    <= '0;
                    timeout_q <= 1'b1;
                    state_q   <= IDLE;
                    rr_ptr_q  <= rr_ptr_d;
                end else idle_q <= idle_q + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_feed_bundle_arbiter.sv
// tb_feed_bundle_arbiter: random bundle sources and backpressure checked against a bundle-level model.
module tb_feed_bundle_arbiter;
    localparam int N = 3;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    feed_bundle_arbiter_if #(.N_REQ(N), .MSG_W(W)) bus ();
    feed_bundle_arbiter #(.N_REQ(N), .MSG_W(W), .TIMEOUT(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    bit          cv[N];
    logic [W-1:0] cd[N];
    bit          cl[N];
    int          rem[N];
    int          seq[N];
    int unsigned cnt[N];
    int          owner, gnt, ptr;
    bit          orr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_v[i] = cv[i];
            bus.req_d[i*W +: W] = cd[i];
            bus.req_last[i] = cl[i];
        end
        bus.out_r = orr;
    endtask

    task automatic model_reset();
        owner = -1;
        gnt = 0;
        ptr = 0;
        for (int i = 0; i < N; i++) begin
            cv[i] = 1'b0;
            cd[i] = '0;
            cl[i] = 1'b0;
            rem[i] = 0;
            cnt[i] = 0;
        end
    endtask

    // Each source holds an offered beat until it is taken; new beats appear at random.
    task automatic gen_sources();
        for (int i = 0; i < N; i++) begin
            if (!cv[i] && $urandom_range(0, 3) != 0) begin
                if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                cv[i] = 1'b1;
                cd[i] = {4'(i), 16'(seq[i])};
                cl[i] = (rem[i] == 1);
            end
        end
    endtask

    task automatic check_all();
        bit ev;
        logic [N-1:0] er;
        ev = (owner >= 0) && cv[owner];
        er = '0;
        if (owner >= 0 && orr) er[owner] = 1'b1;
        check("out_v", 64'(bus.out_v), 64'(ev));
        check("req_r", 64'(bus.req_r), 64'(er));
        check("out_src", 64'(bus.out_src), 64'(gnt));
        if (ev) begin
            check("out_d", 64'(bus.out_d), 64'(cd[owner]));
            check("out_last", 64'(bus.out_last), 64'(cl[owner]));
        end
        for (int i = 0; i < N; i++) check("bundle_cnt", 64'(bus.bundle_cnt[i*32 +: 32]), 64'(cnt[i]));
        check("timeout_err", 64'(bus.timeout_err), 64'd0);
    endtask

    // Bundle-level rules: free stream picks the next requester after the last winner,
    // an owned stream moves only the owner's beats and frees after its last beat.
    task automatic step();
        int j;
        int o;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (cv[j]) begin
                    owner = j;
                    gnt = j;
                    break;
                end
            end
        end else if (cv[owner] && orr) begin
            o = owner;
            cv[o] = 1'b0;
            rem[o]--;
            seq[o]++;
            if (cl[o]) begin
                cnt[o]++;
                ptr = (o + 1) % N;
                owner = -1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        model_reset();
        bus.req_v = '1;
        bus.req_d = '0;
        bus.req_last = '0;
        bus.out_r = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_v", 64'(bus.out_v), 64'd0);
        check("rst_req_r", 64'(bus.req_r), 64'd0);
        check("rst_out_src", 64'(bus.out_src), 64'd0);
        check("rst_cnt", 64'(bus.bundle_cnt), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            gen_sources();
            orr = ($urandom_range(0, 3) != 0);
            drive();
            #1;
            if (c == 2000) begin
                rst = 1'b1;
                #1;
                check("arst_out_v", 64'(bus.out_v), 64'd0);
                check("arst_req_r", 64'(bus.req_r), 64'd0);
                check("arst_out_src", 64'(bus.out_src), 64'd0);
                model_reset();
                drive();
                @(posedge clk);
                #1;
                check("arst_cnt", 64'(bus.bundle_cnt), 64'd0);
                rst = 1'b0;
                continue;
            end
            check_all();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
